bg_band_renderer: RTL and testbench

// - Parametrised background layer generator for the GPU pixel pipeline. It sits between the
//   VGA timing counters and the palette lookup.
// - Each visible pixel resolves to a palette index:
//   - rows above the band -> sky index;
//   - rows below the band -> ground index;
//   - rows inside the band -> index unpacked from packed pattern-ROM words.
// - Horizontal scroll with row wrap-around. Fixed 2-cycle pipelined latency.

---
 rtl/bg_band_renderer.sv | 227 ++++++++++++++++++++++
 tb/tb_bg_band_renderer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/bg_band_renderer.sv
// bg_band_renderer: sky / pattern-band / ground palette index generator.
// Optional feature macro BG_AUTOSCROLL_EN adds per-frame automatic scroll.
module bg_band_renderer #(
  parameter int X_W           = 10,
  parameter int PIX_BITS      = 3,
  parameter int PIX_PER_WORD  = 3,
  parameter int ADDR_W        = 11,
  parameter int WORDS_PER_ROW = 16,
  parameter int BAND_TOP      = 300,
  parameter int BAND_H        = 128,
  parameter int INDEX_W       = 9,
  parameter int SKY_IDX       = 5,
  parameter int GROUND_IDX    = 7
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             pix_valid,
  input  logic [X_W-1:0]                   x,
  input  logic [X_W-1:0]                   y,
  input  logic [ADDR_W-1:0]                scroll_word,
  input  logic [1:0]                       scroll_slot,
`ifdef BG_AUTOSCROLL_EN
  input  logic                             auto_scroll,
`endif
  output logic                             mem_en,
  output logic [ADDR_W-1:0]                mem_addr,
  input  logic [PIX_BITS*PIX_PER_WORD-1:0] mem_rdata,
  output logic                             index_valid,
  output logic [INDEX_W-1:0]               index_out
);

  localparam logic [ADDR_W-1:0] WLAST = ADDR_W'(WORDS_PER_ROW - 1);
  localparam logic [ADDR_W-1:0] WROW  = ADDR_W'(WORDS_PER_ROW);
  localparam logic [1:0]        SLAST = 2'(PIX_PER_WORD - 1);
  localparam logic [2:0]        SNUM  = 3'(PIX_PER_WORD);
  localparam logic [X_W-1:0]    YTOP  = X_W'(BAND_TOP);
  localparam logic [X_W-1:0]    YBOT  = X_W'(BAND_TOP + BAND_H);

  typedef enum logic [1:0] {
    CL_SKY  = 2'd0,
    CL_BAND = 2'd1,
    CL_GND  = 2'd2
  } cls_t;

  // One-pixel advance of a {word, slot} position with horizontal wrap.
  function automatic logic [ADDR_W+1:0] adv(
    input logic [ADDR_W-1:0] w,
    input logic [1:0]        s
  );
    logic [ADDR_W-1:0] nw;
    logic [1:0]        ns;
    nw = w;
    ns = s + 2'd1;
    if (s == SLAST) begin
      ns = 2'd0;
      nw = (w == WLAST) ? '0 : w + ADDR_W'(1);
    end
    return {nw, ns};
  endfunction

  logic              line_start;
  logic              frame_start;
  logic [ADDR_W-1:0] san_word;
  logic [1:0]        san_slot;
  logic [ADDR_W-1:0] src_word;
  logic [1:0]        src_slot;
  logic [ADDR_W-1:0] lat_word;
  logic [1:0]        lat_slot;
  logic [ADDR_W-1:0] word_q;
  logic [1:0]        slot_q;
  logic [ADDR_W-1:0] cur_word;
  logic [1:0]        cur_slot;
  logic [ADDR_W+1:0] nxt_pos;
  cls_t              cls;
  logic              band_hit;
  logic [X_W-1:0]    row;
  logic [ADDR_W-1:0] calc_addr;
  logic [ADDR_W-1:0] addr_q;
  logic              s1_valid;
  cls_t              s1_class;
  logic [1:0]        s1_slot;
  logic [PIX_BITS-1:0] pix;

  assign line_start  = pix_valid && (x == '0);
  assign frame_start = line_start && (y == '0);

  // Clamp out-of-range scroll requests to legal positions.
  always_comb begin
    san_word = (scroll_word >= WROW) ? '0 : scroll_word;
    san_slot = ({1'b0, scroll_slot} >= SNUM) ? SLAST : scroll_slot;
  end

`ifdef BG_AUTOSCROLL_EN
  logic [ADDR_W-1:0] as_word;
  logic [1:0]        as_slot;
  logic [ADDR_W+1:0] as_nxt;

  assign as_nxt = adv(as_word, as_slot);

  // Scroll source: running auto counter or the port value.
  always_comb begin
    src_word = san_word;
    src_slot = san_slot;
    if (auto_scroll) begin
      src_word = as_word;
      src_slot = as_slot;
    end
  end

  // Auto-scroll counter steps one pixel per frame, or reloads from ports.
  always_ff @(posedge clk) begin
    if (rst) begin
      as_word <= '0;
      as_slot <= '0;
    end else if (frame_start) begin
      if (auto_scroll) begin
        as_word <= as_nxt[ADDR_W+1:2];
        as_slot <= as_nxt[1:0];
      end else begin
        as_word <= san_word;
        as_slot <= san_slot;
      end
    end
  end
`else
  assign src_word = san_word;
  assign src_slot = san_slot;
`endif

  // Position of the pixel presented this cycle; a frame start uses its new scroll.
  always_comb begin
    cur_word = word_q;
    cur_slot = slot_q;
    if (frame_start) begin
      cur_word = src_word;
      cur_slot = src_slot;
    end else if (line_start) begin
      cur_word = lat_word;
      cur_slot = lat_slot;
    end
  end

  assign nxt_pos = adv(cur_word, cur_slot);

  // Frame scroll latch and per-pixel word/slot counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_word <= '0;
      lat_slot <= '0;
      word_q   <= '0;
      slot_q   <= '0;
    end else if (pix_valid) begin
      word_q <= nxt_pos[ADDR_W+1:2];
      slot_q <= nxt_pos[1:0];
      if (frame_start) begin
        lat_word <= src_word;
        lat_slot <= src_slot;
      end
    end
  end

  // Row classification and pattern ROM address.
  always_comb begin
    cls = CL_BAND;
    if (y < YTOP) begin
      cls = CL_SKY;
    end else if (y >= YBOT) begin
      cls = CL_GND;
    end
    row       = y - YTOP;
    calc_addr = ADDR_W'(row) * WROW + cur_word;
    band_hit  = pix_valid && !rst && (cls == CL_BAND);
  end

  // ROM request goes out in the pixel's own cycle; address holds otherwise.
  always_comb begin
    mem_en   = band_hit;
    mem_addr = band_hit ? calc_addr : addr_q;
  end

  // Stage 1: remember address, class and slot while the ROM reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q   <= '0;
      s1_valid <= 1'b0;
      s1_class <= CL_SKY;
      s1_slot  <= '0;
    end else begin
      s1_valid <= pix_valid;
      if (band_hit) begin
        addr_q <= calc_addr;
      end
      if (pix_valid) begin
        s1_class <= cls;
        s1_slot  <= cur_slot;
      end
    end
  end

  // Slot 0 lives in the most significant field of the ROM word.
  always_comb begin
    pix = '0;
    for (int i = 0; i < PIX_PER_WORD; i++) begin
      if (s1_slot == 2'(i)) begin
        pix = mem_rdata[(PIX_PER_WORD-1-i)*PIX_BITS +: PIX_BITS];
      end
    end
  end

  // Stage 2: registered palette index; holds while no pixel arrives.
  always_ff @(posedge clk) begin
    if (rst) begin
      index_valid <= 1'b0;
      index_out   <= '0;
    end else begin
      index_valid <= s1_valid;
      if (s1_valid) begin
        unique case (1'b1)
          (s1_class == CL_BAND): index_out <= INDEX_W'(pix);
          (s1_class == CL_SKY):  index_out <= INDEX_W'(SKY_IDX);
          default:               index_out <= INDEX_W'(GROUND_IDX);
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bg_band_renderer.sv
// tb_bg_band_renderer: directed table-driven bench for bg_band_renderer.
// Build with BG_AUTOSCROLL_EN defined to also exercise auto scroll.
module tb_bg_band_renderer;

  logic        clk = 1'b0;
  logic        rst;
  logic        pix_valid;
  logic [9:0]  x;
  logic [9:0]  y;
  logic [10:0] scroll_word;
  logic [1:0]  scroll_slot;
  logic        mem_en;
  logic [10:0] mem_addr;
  logic [8:0]  mem_rdata;
  logic        index_valid;
  logic [8:0]  index_out;
`ifdef BG_AUTOSCROLL_EN
  logic        auto_scroll;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  bg_band_renderer dut (
    .clk         (clk),
    .rst         (rst),
    .pix_valid   (pix_valid),
    .x           (x),
    .y           (y),
    .scroll_word (scroll_word),
    .scroll_slot (scroll_slot),
`ifdef BG_AUTOSCROLL_EN
    .auto_scroll (auto_scroll),
`endif
    .mem_en      (mem_en),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .index_valid (index_valid),
    .index_out   (index_out)
  );

  function automatic logic [8:0] rom_word(input int a);
    return 9'(a * 37 + 83);
  endfunction

  function automatic int rom_pix(input int a, input int s);
    logic [8:0] w;
    w = rom_word(a);
    return int'((w >> ((2 - s) * 3)) & 9'd7);
  endfunction

  // Synchronous ROM model, one-cycle read.
  always @(posedge clk) begin
    if (mem_en) mem_rdata <= rom_word(int'(mem_addr));
  end

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step(input logic pv, input int xi, input int yi,
                      input int sw, input int ss);
    @(negedge clk);
    pix_valid   = pv;
    x           = 10'(xi);
    y           = 10'(yi);
    scroll_word = 11'(sw);
    scroll_slot = 2'(ss);
  endtask

  typedef struct {
    logic pv;
    int   x;
    int   y;
    int   sw;
    int   ss;
    logic en;
    int   addr;
    int   idx;
  } vec_t;

  vec_t vec[$];

  function automatic void mk(input logic pv, input int xi, input int yi,
                             input int sw, input int ss, input logic en,
                             input int addr, input int slot);
    vec_t v;
    v.pv = pv; v.x = xi; v.y = yi; v.sw = sw; v.ss = ss;
    v.en = en; v.addr = addr;
    if (en) v.idx = rom_pix(addr, slot);
    else    v.idx = (yi < 300) ? 5 : 7;
    vec.push_back(v);
  endfunction

  initial begin
    int hold;
    rst = 1'b1; pix_valid = 1'b0; x = '0; y = '0;
    scroll_word = '0; scroll_slot = '0; mem_rdata = '0;
`ifdef BG_AUTOSCROLL_EN
    auto_scroll = 1'b0;
`endif
    repeat (3) @(negedge clk);
    #1;
    chk("reset index_valid", int'(index_valid), 0);
    chk("reset index_out", int'(index_out), 0);
    chk("reset mem_en", int'(mem_en), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    //  pv x   y   sw  ss en addr slot
    mk(1, 0,  0,   0, 0, 0, 0,    0);
    mk(1, 1,  0,   0, 0, 0, 0,    0);
    mk(1, 0,  299, 0, 0, 0, 0,    0);
    mk(1, 0,  300, 0, 0, 1, 0,    0);
    mk(1, 1,  300, 0, 0, 1, 0,    1);
    mk(1, 2,  300, 0, 0, 1, 0,    2);
    mk(1, 3,  300, 0, 0, 1, 1,    0);
    mk(0, 4,  300, 0, 0, 0, 0,    0);
    mk(1, 4,  300, 0, 0, 1, 1,    1);
    mk(0, 5,  300, 0, 0, 0, 0,    0);
    mk(1, 5,  300, 0, 0, 1, 1,    2);
    mk(1, 0,  301, 0, 0, 1, 16,   0);
    mk(1, 0,  427, 0, 0, 1, 2032, 0);
    mk(1, 0,  428, 0, 0, 0, 0,    0);
    mk(1, 47, 428, 0, 0, 0, 0,    0);
    mk(1, 0,  0,  15, 2, 0, 0,    0);
    mk(1, 0,  300, 3, 0, 1, 15,   2);
    mk(1, 1,  300, 3, 0, 1, 0,    0);
    mk(1, 2,  300, 3, 0, 1, 0,    1);
    mk(1, 0,  301, 3, 0, 1, 31,   2);
    mk(1, 0,  0,  20, 3, 0, 0,    0);
    mk(1, 0,  300, 0, 0, 1, 0,    2);
    mk(1, 1,  300, 0, 0, 1, 1,    0);

    hold = 0;
    for (int i = 0; i < vec.size() + 2; i++) begin
      if (i < vec.size())
        step(vec[i].pv, vec[i].x, vec[i].y, vec[i].sw, vec[i].ss);
      else
        step(1'b0, 0, 0, 0, 0);
      #1;
      if (i < vec.size()) begin
        chk($sformatf("v%0d mem_en", i), int'(mem_en), int'(vec[i].en));
        if (vec[i].en)
          chk($sformatf("v%0d mem_addr", i), int'(mem_addr), vec[i].addr);
      end
      if (i >= 2) begin
        chk($sformatf("v%0d index_valid", i - 2), int'(index_valid),
            int'(vec[i-2].pv));
        if (vec[i-2].pv) begin
          chk($sformatf("v%0d index_out", i - 2), int'(index_out),
              vec[i-2].idx);
          hold = vec[i-2].idx;
        end else begin
          chk($sformatf("v%0d index_hold", i - 2), int'(index_out), hold);
        end
      end
    end

    // Reset in the middle of band traffic.
    for (int k = 0; k < 4; k++) step(1'b1, k, 300, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    x = 10'd4;
    #1;
    chk("rst mem_en", int'(mem_en), 0);
    @(negedge clk);
    #1;
    chk("rst index_valid", int'(index_valid), 0);
    chk("rst index_out", int'(index_out), 0);
    chk("rst mem_en held", int'(mem_en), 0);
    @(negedge clk);
    rst = 1'b0;
    pix_valid = 1'b0;
    step(1'b0, 0, 0, 0, 0);
    step(1'b1, 0, 305, 9, 1);
    #1;
    chk("post-rst mem_addr", int'(mem_addr), 80);
    step(1'b0, 0, 0, 0, 0);
    step(1'b0, 0, 0, 0, 0);
    #1;
    chk("post-rst index_valid", int'(index_valid), 1);
    chk("post-rst index_out", int'(index_out), rom_pix(80, 0));

`ifdef BG_AUTOSCROLL_EN
    auto_scroll = 1'b1;
    for (int f = 0; f < 4; f++) begin
      int ew;
      int es;
      ew = (f == 3) ? 1 : 0;
      es = (f == 3) ? 0 : f;
      step(1'b1, 0, 0, 7, 1);
      step(1'b1, 0, 300, 7, 1);
      #1;
      chk($sformatf("auto f%0d mem_addr", f), int'(mem_addr), ew);
      step(1'b0, 0, 0, 0, 0);
      step(1'b0, 0, 0, 0, 0);
      #1;
      chk($sformatf("auto f%0d index_out", f), int'(index_out),
          rom_pix(ew, es));
    end
    auto_scroll = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
